// File: rtl/ballot_collector.sv
// ballot_collector: opens a four-voter session, collects yes/no pulses, closes on full vote or TIMEOUT.
// Define BALLOT_COLLECTOR_REVOTE_EN to let voters overwrite their vote and close only by timeout.
module ballot_collector #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_yes,
  input  logic [3:0] vote_no,
  input  logic       ack,
  output logic [3:0] ballot,
  output logic       ballot_valid,
  output logic [3:0] voted,
  output logic       busy,
  output logic       timed_out
);
  typedef enum logic [1:0] {IDLE, OPEN, CLOSED} state_t;
  state_t state;
  logic [15:0] timer;
  logic [3:0] rec;
  logic [3:0] next_ballot;
  logic close_early;
  always_comb begin
`ifdef BALLOT_COLLECTOR_REVOTE_EN
    rec = vote_yes ^ vote_no;
    close_early = 1'b0;
`else
    rec = (vote_yes ^ vote_no) & ~voted;
    close_early = &voted;
`endif
    next_ballot = (ballot & ~rec) | (vote_yes & rec);
  end
  // timer counts sampled OPEN cycles; reaching TIMEOUT means the last sampling edge has passed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ballot <= '0;
      voted <= '0;
      ballot_valid <= 1'b0;
      busy <= 1'b0;
      timed_out <= 1'b0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= OPEN;
          busy <= 1'b1;
          ballot <= '0;
          voted <= '0;
          timed_out <= 1'b0;
          timer <= '0;
        end
        OPEN: if (close_early || timer == 16'(TIMEOUT)) begin
          state <= CLOSED;
          busy <= 1'b0;
          ballot_valid <= 1'b1;
          timed_out <= ~&voted;
        end else begin
          ballot <= next_ballot;
          voted <= voted | rec;
          timer <= timer + 16'd1;
        end
        CLOSED: if (ack) begin
          state <= IDLE;
          ballot_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector: directed stimulus with a scoreboard checking each closed ballot.
module tb_ballot_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic [3:0] vote_yes = '0;
  logic [3:0] vote_no = '0;
  logic [3:0] ballot;
  logic [3:0] voted;
  logic ballot_valid;
  logic busy;
  logic timed_out;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k;
  logic prev_valid = 1'b0;
  typedef struct {
    logic [3:0] ballot;
    logic [3:0] voted;
    logic       to;
    int         edge_no;
  } exp_t;
  exp_t sb[$];

  ballot_collector #(.TIMEOUT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .ack(ack), .ballot(ballot), .ballot_valid(ballot_valid), .voted(voted),
    .busy(busy), .timed_out(timed_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] b, input logic [3:0] v, input logic t, input int e);
    exp_t x;
    x.ballot = b;
    x.voted = v;
    x.to = t;
    x.edge_no = e;
    sb.push_back(x);
  endtask

  // monitor: every rising ballot_valid is matched against the next scoreboard entry
  always @(negedge clk) begin
    if (ballot_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(ballot_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ballot", 32'(ballot), 32'(e.ballot));
        chk("sb_voted", 32'(voted), 32'(e.voted));
        chk("sb_timed_out", 32'(timed_out), 32'(e.to));
        chk("sb_edge", 32'(cyc), 32'(e.edge_no));
      end
    end
    prev_valid <= ballot_valid;
  end

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
  endtask

  task automatic vote(input logic [3:0] y, input logic [3:0] n);
    vote_yes = y;
    vote_no = n;
    tick();
    vote_yes = '0;
    vote_no = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ballot", 32'(ballot), 0);
    chk("rst_valid", 32'(ballot_valid), 0);
    chk("rst_voted", 32'(voted), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timed_out", 32'(timed_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    // early close
    do_start();
    chk("start_busy", 32'(busy), 1);
    push(4'b0101, 4'b1111, 1'b0, k + 2);
    vote(4'b0101, 4'b1010);
    chk("early_voted", 32'(voted), 32'hf);
    chk("early_busy_open", 32'(busy), 1);
    tick();
    chk("early_busy_closed", 32'(busy), 0);
    tick();
    do_ack();
    chk("ack_valid", 32'(ballot_valid), 0);
    chk("ack_ballot_held", 32'(ballot), 32'h5);
    // timeout with only voter 2
    do_start();
    chk("restart_ballot_cleared", 32'(ballot), 0);
    push(4'b0100, 4'b0100, 1'b1, k + 6);
    vote(4'b0100, 4'b0000);
    repeat (3) tick();
    chk("to_still_open", 32'(busy), 1);
    chk("to_not_valid", 32'(ballot_valid), 0);
    repeat (2) tick();
    chk("to_closed_busy", 32'(busy), 0);
    do_ack();
    // conflict, duplicate, start during OPEN
    do_start();
    chk("start_clears_timed_out", 32'(timed_out), 0);
    vote(4'b0001, 4'b0001);
    chk("conflict_voted", 32'(voted), 0);
    vote(4'b0001, 4'b0000);
    chk("second_yes_voted", 32'(voted), 1);
    chk("second_yes_ballot", 32'(ballot), 1);
    start = 1'b1;
    vote(4'b0000, 4'b0001);
    start = 1'b0;
    chk("dup_no_ignored", 32'(ballot), 1);
    push(4'b0011, 4'b1111, 1'b0, k + 5);
    vote(4'b0010, 4'b1100);
    tick();
    chk("conflict_closed", 32'(ballot_valid), 1);
    // start together with ack must be ignored
    start = 1'b1;
    do_ack();
    start = 1'b0;
    chk("ack_start_busy", 32'(busy), 0);
    chk("ack_start_valid", 32'(ballot_valid), 0);
    tick();
    chk("stays_idle", 32'(busy), 0);
    // reset mid-session
    do_start();
    vote(4'b0011, 4'b0000);
    chk("pre_reset_voted", 32'(voted), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_voted", 32'(voted), 0);
    chk("async_ballot", 32'(ballot), 0);
    chk("async_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    do_start();
    chk("clean_voted", 32'(voted), 0);
    chk("clean_busy", 32'(busy), 1);
    push(4'b0000, 4'b0000, 1'b1, k + 6);
    repeat (7) tick();
    do_ack();
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
